array_drain: RTL and testbench

Output collector for the systolic array. It samples the array's column-skewed `down_out` results, where lane j lags lane 0 by j cycles, and deskews them into whole aligned rows. It buffers those rows in a small FIFO and presents them to the downstream result buffer over a valid/ready handshake. The array cannot be stalled, so the FIFO absorbs backpressure and an overflow flag records any dropped row.

---
 rtl/array_drain.sv | 145 ++++++++++++++
 tb/tb_array_drain.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/array_drain.sv
// array_drain: deskews column-skewed systolic array results into aligned rows
// and buffers them in a small FIFO behind a valid/ready handshake.
module array_drain #(
    parameter int N          = 256,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       down_in [N],
    input  logic             start,
    input  logic [CNT_W-1:0] row_count,
    output logic [7:0]       out_row [N],
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow
);
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW  = AW + 1;
    localparam int WW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((N > 2) ? N - 3 : 0);
    localparam logic [OW-1:0] FULL_CNT  = OW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [7:0] aligned [N];

    // Lane j is delayed N-1-j cycles so every lane lines up with lane N-1.
    for (genvar j = 0; j < N; j++) begin : g_lane
        localparam int D = N - 1 - j;
        if (D == 0) begin : g_pass
            assign aligned[j] = down_in[j];
        end else begin : g_sr
            logic [7:0] sr_q [D];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < D; k++) sr_q[k] <= '0;
                end else begin
                    sr_q[0] <= down_in[j];
                    for (int k = 1; k < D; k++) sr_q[k] <= sr_q[k-1];
                end
            end
            assign aligned[j] = sr_q[D-1];
        end
    end

    logic [1:0]       state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] rows_q, rows_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             ovf_q;
    logic             wr;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        rows_d  = rows_q;
        rcnt_d  = rcnt_q;
        wr      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d = row_count;
                    rcnt_d = '0;
                    wait_d = '0;
                    if (row_count == '0) state_d = S_FIN;
                    else if (N <= 2)     state_d = S_DRAIN;
                    else                 state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_d = wait_q + WW'(1);
                if (wait_q == WAIT_LAST) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                wr     = 1'b1;
                rcnt_d = rcnt_q + CNT_W'(1);
                if (rcnt_d == rows_q) state_d = S_FIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [7:0]    mem_q [FIFO_DEPTH][N];
    logic [7:0]    out_row_q [N];
    logic [7:0]    head_d [N];
    logic [AW-1:0] wp_q, rp_q, rp_d;
    logic [OW-1:0] cnt_q, cnt_d;
    logic          pop, wr_ok;

    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    // A same-cycle pop frees the slot, so a write into a full FIFO still lands.
    assign wr_ok     = wr && ((cnt_q != FULL_CNT) || pop);
    assign rp_d      = pop ? rp_q + AW'(1) : rp_q;
    assign cnt_d     = cnt_q + OW'(wr_ok) - OW'(pop);

    always_comb begin
        head_d = out_row_q;
        if (cnt_d != '0) begin
            if (wr_ok && (wp_q == rp_d)) head_d = aligned;
            else                         head_d = mem_q[rp_d];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wp_q] <= aligned;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            rows_q  <= '0;
            rcnt_q  <= '0;
            ovf_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            for (int j = 0; j < N; j++) out_row_q[j] <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            rows_q    <= rows_d;
            rcnt_q    <= rcnt_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            out_row_q <= head_d;
            if (wr_ok) wp_q <= wp_q + AW'(1);
            if (state_q == S_IDLE && start) ovf_q <= 1'b0;
            else if (wr && !wr_ok)          ovf_q <= 1'b1;
        end
    end

    assign out_row  = out_row_q;
    assign busy     = (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign done     = (state_q == S_FIN);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_array_drain.sv
// Bench for array_drain: directed scenarios plus random traffic checked
// against a queue-based model of row timing and FIFO contents.
module tb_array_drain;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int CW = 16;

    typedef logic [8*N-1:0] row_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    down_in [N];
    logic          start;
    logic [CW-1:0] row_count;
    logic [7:0]    out_row [N];
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          overflow;

    array_drain #(.N(N), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .down_in(down_in),
        .start(start),
        .row_count(row_count),
        .out_row(out_row),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    row_t hist [int];
    row_t q [$];
    bit   m_ovf = 1'b0;
    int   s_cyc = 0;
    int   m_rows = 0;
    int   done_cyc = -1;

    function automatic row_t pack(input logic [7:0] a [N]);
        row_t r;
        for (int j = 0; j < N; j++) r[8*j +: 8] = a[j];
        return r;
    endfunction

    task automatic chk(input string tag, input row_t got, input row_t exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_rows   = 0;
        done_cyc = -1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, row_t'(out_valid), '0);
        chk({tag, "_busy"},  row_t'(busy),      '0);
        chk({tag, "_done"},  row_t'(done),      '0);
        chk({tag, "_ovf"},   row_t'(overflow),  '0);
        chk({tag, "_row"},   pack(out_row),     '0);
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic step(input bit st, input int m, input bit rdy);
        row_t cur, w;
        bit   pop, wr, e_busy;
        int   r;
        for (int j = 0; j < N; j++) begin
            down_in[j]    = 8'($urandom);
            cur[8*j +: 8] = down_in[j];
        end
        hist[cyc] = cur;
        start     = st;
        row_count = CW'(m);
        out_ready = rdy;
        #1;
        e_busy = (m_rows > 0) && (cyc >= s_cyc + 1) && (cyc <= s_cyc + N + m_rows - 2);
        chk("valid", row_t'(out_valid), row_t'(q.size() != 0));
        if (q.size() != 0) chk("row", pack(out_row), q[0]);
        chk("busy", row_t'(busy),     row_t'(e_busy));
        chk("done", row_t'(done),     row_t'(cyc == done_cyc));
        chk("ovf",  row_t'(overflow), row_t'(m_ovf));
        pop = (q.size() != 0) && rdy;
        wr  = (m_rows > 0) && (cyc >= s_cyc + N - 1) && (cyc <= s_cyc + N - 2 + m_rows);
        w   = '0;
        if (wr) begin
            r = cyc - (s_cyc + N - 1);
            for (int j = 0; j < N; j++) w[8*j +: 8] = hist[s_cyc + r + j][8*j +: 8];
        end
        if (pop) void'(q.pop_front());
        if (wr) begin
            if (q.size() < D) q.push_back(w);
            else m_ovf = 1'b1;
        end
        if (st && cyc > done_cyc) begin
            s_cyc    = cyc;
            m_rows   = m;
            m_ovf    = 1'b0;
            done_cyc = (m == 0) ? cyc + 1 : cyc + N + m - 1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        row_count = '0;
        for (int j = 0; j < N; j++) down_in[j] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        reset = 1'b0;

        // basic deskew, M=3
        step(1, 3, 1);
        repeat (8) step(0, 0, 1);

        // backpressure, M=4
        step(1, 4, 0);
        repeat (7) step(0, 0, 0);
        repeat (6) step(0, 0, 1);

        // overflow, M=6
        step(1, 6, 0);
        repeat (9) step(0, 0, 0);
        chk("ovf_sticky", row_t'(overflow), row_t'(1));
        repeat (6) step(0, 0, 1);

        // full with simultaneous pop, M=5
        step(1, 5, 0);
        repeat (6) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("full_pop_ovf", row_t'(overflow), row_t'(0));
        repeat (6) step(0, 0, 1);

        // M=0, then starts during busy and during FIN are ignored
        step(1, 0, 1);
        repeat (2) step(0, 0, 1);
        step(1, 3, 1);
        step(1, 2, 1);
        step(0, 0, 1);
        step(1, 5, 1);
        step(0, 0, 1);
        step(1, 7, 1);
        step(1, 1, 1);
        step(1, 1, 1);
        repeat (6) step(0, 0, 1);

        // reset mid-DRAIN, after row 1 is written
        step(1, 4, 1);
        repeat (4) step(0, 0, 1);
        reset = 1'b1;
        #1;
        check_zero("mid_rst");
        #2;
        reset = 1'b0;
        model_reset();
        step(1, 2, 1);
        repeat (8) step(0, 0, 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) != 0));
        end
        repeat (20) step(0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
